s_port_frame_ctrl: RTL and testbench

Frame-level controller that sits after the serial-port byte receiver and sequences its output into configuration write transactions. It hunts for a header byte, collects address, length, payload and (optionally) checksum, buffers the payload, and commits it as a burst of register writes only after the whole frame has been validated. Parity failures, bad lengths, checksum mismatches and inter-byte timeouts abort the frame, are flagged, and are counted.

---
 rtl/s_port_frame_ctrl.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_s_port_frame_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_port_frame_ctrl.sv
// s_port_frame_ctrl
// -----------------------------------------------------------------------------
// Frame sequencer placed behind the serial-port byte receiver. It hunts for a
// HEADER byte and then collects ADDR, LEN, LEN payload bytes and, when enabled,
// a CKSUM byte. The payload is held in a small buffer. It is written out as a
// burst of register writes only after the whole frame has been validated.
// Parity failures, bad lengths, checksum mismatches and inter-byte timeouts
// abort the frame. Each abort pulses frame_err, updates err_code and bumps
// err_cnt.
//
// Optional feature macro: S_PORT_FRAME_CKSUM_EN
//   defined   : a CKSUM byte follows the payload. It must equal
//               (ADDR + LEN + sum of DATA) mod 256. A mismatch aborts with
//               code 3.
//   undefined : there is no CKSUM byte. DATA goes straight to COMMIT.
//
// Parameters
//   HEADER        frame start byte
//   MAX_LEN       largest accepted payload length (1..32). It also sets the
//                 buffer depth.
//   TIMEOUT_VALUE clk cycles allowed between accepted bytes inside a frame.
//                 Must be 2 or more.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high
//   byte_in     received byte
//   byte_in_en  one-cycle strobe; byte_in and parity_ok are valid
//   parity_ok   parity result for byte_in
//   wr_addr     register write address (ADDR + i, wraps at 8 bits)
//   wr_data     register write data (buffer[i])
//   wr_en       write strobe, one cycle per payload byte
//   frame_done  one-cycle pulse after the last write of a committed frame
//   frame_err   one-cycle pulse when a frame is aborted
//   err_code    last error: 0 timeout, 1 parity, 2 length, 3 checksum
//   err_cnt     aborted-frame count, saturates at 255
//   busy        high in every state except IDLE
// -----------------------------------------------------------------------------
module s_port_frame_ctrl #(
    parameter logic [7:0]  HEADER        = 8'hAA,
    parameter logic [5:0]  MAX_LEN       = 6'd32,
    parameter logic [19:0] TIMEOUT_VALUE = 20'hFFFFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_in_en,
    input  logic       parity_ok,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       wr_en,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic [7:0] err_cnt,
    output logic       busy
);

    localparam int AW = (MAX_LEN > 6'd1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  MAX_LEN_B    = {2'b00, MAX_LEN};
    // The gap counter starts at 0 in the first cycle after an accepted byte.
    // The abort is registered, so it fires when the incremented count reaches
    // TIMEOUT_VALUE-1. That puts frame_err exactly TIMEOUT_VALUE cycles after
    // the last accepted strobe.
    localparam logic [19:0] TIMEOUT_LAST = TIMEOUT_VALUE - 20'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
`ifdef S_PORT_FRAME_CKSUM_EN
        ST_CKSUM,
`endif
        ST_COMMIT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  idx_q, idx_d;
    logic [19:0] timer_q, timer_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q;
    logic        wr_en_q, wr_en_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_err_q, frame_err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        busy_q, busy_d;
`ifdef S_PORT_FRAME_CKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    logic        buf_we;
    logic        rd_en;
    logic        abort;
    logic [1:0]  abort_code;

    // Payload buffer. There is no reset: contents are only read back after a
    // complete, validated frame has overwritten every entry in use.
    logic [7:0]  frame_buf [0:MAX_LEN-1];

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        idx_d        = idx_q;
        timer_d      = timer_q;
        wr_addr_d    = wr_addr_q;
        wr_en_d      = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        err_code_d   = err_code_q;
        err_cnt_d    = err_cnt_q;
        buf_we       = 1'b0;
        rd_en        = 1'b0;
        abort        = 1'b0;
        abort_code   = 2'd0;
`ifdef S_PORT_FRAME_CKSUM_EN
        sum_d        = sum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                timer_d = 20'd0;
                // Anything other than a clean header is ignored silently.
                if (byte_in_en && parity_ok && (byte_in == HEADER)) begin
                    state_d = ST_ADDR;
                end
            end

            ST_COMMIT: begin
                // Strobes arriving here are dropped on purpose.
                timer_d = 20'd0;
                if (idx_q < len_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q + idx_q;
                    rd_en     = 1'b1;
                    idx_d     = idx_q + 8'd1;
                end else begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                // ADDR / LEN / DATA / CKSUM: in-frame byte collection.
                if (byte_in_en) begin
                    timer_d = 20'd0;
                    if (!parity_ok) begin
                        // Parity failure outranks length and checksum checks.
                        abort      = 1'b1;
                        abort_code = 2'd1;
                    end else begin
                        case (state_q)
                            ST_ADDR: begin
                                addr_d  = byte_in;
`ifdef S_PORT_FRAME_CKSUM_EN
                                sum_d   = byte_in;
`endif
                                state_d = ST_LEN;
                            end
                            ST_LEN: begin
                                if ((byte_in == 8'd0) || (byte_in > MAX_LEN_B)) begin
                                    abort      = 1'b1;
                                    abort_code = 2'd2;
                                end else begin
                                    len_d   = byte_in;
                                    idx_d   = 8'd0;
`ifdef S_PORT_FRAME_CKSUM_EN
                                    sum_d   = sum_q + byte_in;
`endif
                                    state_d = ST_DATA;
                                end
                            end
                            ST_DATA: begin
                                buf_we = 1'b1;
                                idx_d  = idx_q + 8'd1;
`ifdef S_PORT_FRAME_CKSUM_EN
                                sum_d  = sum_q + byte_in;
`endif
                                if (idx_q == (len_q - 8'd1)) begin
`ifdef S_PORT_FRAME_CKSUM_EN
                                    state_d = ST_CKSUM;
`else
                                    idx_d   = 8'd0;
                                    state_d = ST_COMMIT;
`endif
                                end
                            end
`ifdef S_PORT_FRAME_CKSUM_EN
                            ST_CKSUM: begin
                                if (byte_in != sum_q) begin
                                    abort      = 1'b1;
                                    abort_code = 2'd3;
                                end else begin
                                    idx_d   = 8'd0;
                                    state_d = ST_COMMIT;
                                end
                            end
`endif
                            default: begin
                            end
                        endcase
                    end
                end else begin
                    timer_d = timer_q + 20'd1;
                    if (timer_d == TIMEOUT_LAST) begin
                        abort      = 1'b1;
                        abort_code = 2'd0;
                    end
                end

                if (abort) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                    err_code_d  = abort_code;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= 8'd0;
            len_q        <= 8'd0;
            idx_q        <= 8'd0;
            timer_q      <= 20'd0;
            wr_addr_q    <= 8'd0;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= 2'd0;
            err_cnt_q    <= 8'd0;
            busy_q       <= 1'b0;
`ifdef S_PORT_FRAME_CKSUM_EN
            sum_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            wr_addr_q    <= wr_addr_d;
            wr_en_q      <= wr_en_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
            err_cnt_q    <= err_cnt_d;
            busy_q       <= busy_d;
`ifdef S_PORT_FRAME_CKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    // Buffer write port.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            frame_buf[idx_q[AW-1:0]] <= byte_in;
        end
    end

    // Registered buffer read. This register drives wr_data directly, so the
    // data lines up with wr_addr_q and wr_en_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_data_q <= 8'd0;
        end else if (rd_en) begin
            wr_data_q <= frame_buf[idx_q[AW-1:0]];
        end
    end

    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_en      = wr_en_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;
    assign err_cnt    = err_cnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_s_port_frame_ctrl.sv
// Testbench for s_port_frame_ctrl.
// The bench first runs directed frames from the test plan and then random
// frames. Each random frame is checked against a frame-level reference model.
// The DUT runs with TIMEOUT_VALUE = 100.
module tb_s_port_frame_ctrl;

    localparam logic [19:0] TV = 20'd100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] byte_in = 8'd0;
    logic       byte_in_en = 1'b0;
    logic       parity_ok = 1'b0;
    logic [7:0] wr_addr, wr_data, err_cnt;
    logic       wr_en, frame_done, frame_err, busy;
    logic [1:0] err_code;

    s_port_frame_ctrl #(
        .HEADER(8'hAA),
        .MAX_LEN(6'd32),
        .TIMEOUT_VALUE(TV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .byte_in(byte_in),
        .byte_in_en(byte_in_en),
        .parity_ok(parity_ok),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_en(wr_en),
        .frame_done(frame_done),
        .frame_err(frame_err),
        .err_code(err_code),
        .err_cnt(err_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_cyc = 0;
    int exp_err_cnt = 0;

    // Observations collected by the monitor.
    logic [15:0] obs_wr[$];
    int   n_done = 0, n_err = 0;
    int   done0 = 0, err0 = 0;
    int   first_wr_cyc = -1, done_cyc = -1, err_cyc = -1;
    logic done_busy = 1'b1;

    // Frame under test and the model's expected writes.
    logic [7:0]  fb[$];
    logic        fp[$];
    logic [15:0] exp_wr[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Outputs are sampled on the falling edge, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (wr_en === 1'b1) begin
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            obs_wr.push_back({wr_addr, wr_data});
        end
        if (frame_done === 1'b1) begin
            n_done++;
            done_cyc  = cyc;
            done_busy = busy;
        end
        if (frame_err === 1'b1) begin
            n_err++;
            err_cyc = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Call only at #1 after a posedge. Back-to-back calls give strobes on
    // consecutive cycles.
    task automatic drive(input logic [7:0] b, input logic p);
        byte_in    = b;
        parity_ok  = p;
        byte_in_en = 1'b1;
        last_cyc   = cyc;
        @(posedge clk);
        #1;
        byte_in_en = 1'b0;
    endtask

    task automatic start_frame();
        obs_wr.delete();
        first_wr_cyc = -1;
        done_cyc     = -1;
        err_cyc      = -1;
        done0        = n_done;
        err0         = n_err;
    endtask

    task automatic wait_outcome(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if ((n_done != done0) || (n_err != err0)) break;
            idle(1);
        end
        check({tag, "_outcome"}, 32'((n_done - done0) + (n_err - err0)), 32'd1);
    endtask

    task automatic all_good();
        fp.delete();
        foreach (fb[i]) fp.push_back(1'b1);
    endtask

    // Frame-level reference model. fb[0] is a clean header. The model returns
    // whether the frame commits, the abort code otherwise, and how many bytes
    // the controller consumes before it reaches a verdict.
    task automatic run_model(output logic ok, output logic [1:0] code, output int n_used);
        logic [7:0] addr, len, sum;
        exp_wr.delete();
        ok = 1'b0;
        code = 2'd0;
        n_used = 2;
        if (!fp[1]) begin code = 2'd1; return; end
        addr = fb[1];
        n_used = 3;
        if (!fp[2]) begin code = 2'd1; return; end
        len = fb[2];
        if ((len == 8'd0) || (len > 8'd32)) begin code = 2'd2; return; end
        sum = addr + len;
        for (int i = 0; i < int'(len); i++) begin
            n_used = 4 + i;
            if (!fp[3 + i]) begin code = 2'd1; return; end
            sum = sum + fb[3 + i];
        end
`ifdef S_PORT_FRAME_CKSUM_EN
        n_used = 4 + int'(len);
        if (!fp[3 + int'(len)]) begin code = 2'd1; return; end
        if (fb[3 + int'(len)] != sum) begin code = 2'd3; return; end
`endif
        for (int i = 0; i < int'(len); i++) exp_wr.push_back({addr + 8'(i), fb[3 + i]});
        ok = 1'b1;
    endtask

    task automatic send_frame(input int n, input int gapmax);
        for (int i = 0; i < n; i++) begin
            drive(fb[i], fp[i]);
            if (gapmax > 0) idle(int'($urandom_range(gapmax, 0)));
        end
    endtask

    task automatic check_frame(input string tag, input logic ok, input logic [1:0] code);
        if (ok) begin
            check({tag, "_done"}, 32'(n_done - done0), 32'd1);
            check({tag, "_err"}, 32'(n_err - err0), 32'd0);
            check({tag, "_nwr"}, 32'(obs_wr.size()), 32'(exp_wr.size()));
            for (int i = 0; i < exp_wr.size(); i++) begin
                check({tag, "_wr"}, (i < obs_wr.size()) ? 32'(obs_wr[i]) : 32'hDEAD_BEEF,
                      32'(exp_wr[i]));
            end
        end else begin
            if (exp_err_cnt < 255) exp_err_cnt++;
            check({tag, "_err"}, 32'(n_err - err0), 32'd1);
            check({tag, "_done"}, 32'(n_done - done0), 32'd0);
            check({tag, "_code"}, 32'(err_code), 32'(code));
            check({tag, "_nwr"}, 32'(obs_wr.size()), 32'd0);
        end
        check({tag, "_errcnt"}, 32'(err_cnt), 32'(exp_err_cnt));
        $display("[TB] %s: %s code=%0d writes=%0d err_cnt=%0d", tag,
                 ok ? "commit" : "abort", code, obs_wr.size(), err_cnt);
    endtask

    task automatic do_frame(input string tag, input int gapmax);
        logic ok;
        logic [1:0] code;
        int n;
        run_model(ok, code, n);
        start_frame();
        send_frame(n, gapmax);
        wait_outcome(120, tag);
        idle(2);
        check_frame(tag, ok, code);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_err_code"}, 32'(err_code), 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic ok;
        logic [1:0] code;
        int n, t, nb, nd;
        logic [7:0] a, l, s;

        idle(3);
        reset = 1'b0;
        check_zero("reset");

        // Test plan frame 1: writes, latency and frame_done timing.
        fb = '{8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19};
        all_good();
        run_model(ok, code, n);
        start_frame();
        send_frame(n, 0);
        t = last_cyc;
        wait_outcome(60, "f1");
        idle(2);
        check_frame("f1", ok, code);
        check("f1_w0", 32'(obs_wr.size() > 0 ? obs_wr[0] : 16'h0), 32'h1001);
        check("f1_w2", 32'(obs_wr.size() > 2 ? obs_wr[2] : 16'h0), 32'h1203);
        check("f1_first_wr_lat", 32'(first_wr_cyc - t), 32'd2);
        check("f1_done_lat", 32'(done_cyc - t), 32'd5);
        check("f1_busy_at_done", 32'(done_busy), 32'd0);

        // Address wrap.
        fb = '{8'hAA, 8'hFE, 8'h03, 8'h11, 8'h22, 8'h33, 8'h67};
        all_good();
        do_frame("wrap", 0);
        check("wrap_w1", 32'(obs_wr.size() > 1 ? obs_wr[1] : 16'h0), 32'hFF22);
        check("wrap_w2", 32'(obs_wr.size() > 2 ? obs_wr[2] : 16'h0), 32'h0033);

`ifdef S_PORT_FRAME_CKSUM_EN
        // Checksum mismatch.
        fb = '{8'hAA, 8'h10, 8'h02, 8'h05, 8'h06, 8'h00};
        all_good();
        do_frame("cksum_bad", 0);
        check("cksum_bad_code", 32'(err_code), 32'd3);
`endif

        // Length and parity aborts.
        fb = '{8'hAA, 8'h10, 8'h00};
        all_good();
        do_frame("len0", 1);
        check("len0_code", 32'(err_code), 32'd2);
        fb = '{8'hAA, 8'h10, 8'h21};
        all_good();
        do_frame("len33", 1);
        fb = '{8'hAA, 8'h10, 8'h05};
        all_good();
        fp[1] = 1'b0;
        do_frame("parity", 1);
        check("parity_code", 32'(err_code), 32'd1);

        // Inter-byte timeout.
        start_frame();
        drive(8'hAA, 1'b1);
        drive(8'h10, 1'b1);
        t = last_cyc;
        wait_outcome(150, "timeout");
        idle(2);
        if (exp_err_cnt < 255) exp_err_cnt++;
        check("timeout_lat", 32'(err_cyc - t), 32'(TV));
        check("timeout_code", 32'(err_code), 32'd0);
        check("timeout_errcnt", 32'(err_cnt), 32'(exp_err_cnt));

        // Junk in IDLE is ignored.
        start_frame();
        drive(8'h55, 1'b1);
        drive(8'hAA, 1'b0);
        idle(120);
        check("junk_busy", 32'(busy), 32'd0);
        check("junk_err", 32'(n_err - err0), 32'd0);
        check("junk_errcnt", 32'(err_cnt), 32'(exp_err_cnt));

        // A header inside the payload is data. Headers sent during COMMIT are
        // dropped.
        fb = '{8'hAA, 8'h30, 8'h02, 8'hAA, 8'h55, 8'h31};
        all_good();
        run_model(ok, code, n);
        start_frame();
        send_frame(n, 0);
        drive(8'hAA, 1'b1);
        drive(8'hAA, 1'b1);
        wait_outcome(60, "commit_drop");
        idle(120);
        check_frame("commit_drop", ok, code);
        check("commit_drop_busy", 32'(busy), 32'd0);

        // Random frames checked against the model.
        for (int f = 0; f < 40; f++) begin
            fb.delete();
            fp.delete();
            a = 8'($urandom);
            l = ($urandom_range(9, 0) == 0) ? 8'($urandom_range(40, 0)) : 8'($urandom_range(32, 1));
            fb.push_back(8'hAA); fp.push_back(1'b1);
            fb.push_back(a);     fp.push_back($urandom_range(23, 0) != 0);
            fb.push_back(l);     fp.push_back($urandom_range(23, 0) != 0);
            s = a + l;
            for (int i = 0; i < int'(l); i++) begin
                fb.push_back(8'($urandom));
                fp.push_back($urandom_range(31, 0) != 0);
                s = s + fb[3 + i];
            end
            fb.push_back(($urandom_range(3, 0) != 0) ? s : 8'($urandom));
            fp.push_back($urandom_range(23, 0) != 0);
            do_frame($sformatf("rnd%0d", f), 3);
        end

        // err_cnt saturation.
        for (int f = 0; f < 260; f++) begin
            drive(8'hAA, 1'b1);
            drive(8'h10, 1'b1);
            drive(8'h00, 1'b1);
            idle(1);
        end
        exp_err_cnt = 255;
        check("sat_errcnt", 32'(err_cnt), 32'd255);
        check("sat_code", 32'(err_code), 32'd2);

        // Reset during COMMIT.
        fb = '{8'hAA, 8'h40, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
               8'h08, 8'h6C};
        all_good();
        run_model(ok, code, n);
        start_frame();
        send_frame(n, 0);
        for (int i = 0; i < 20; i++) begin
            if (wr_en === 1'b1) break;
            idle(1);
        end
        check("rst_commit_seen_wr", 32'(wr_en), 32'd1);
        reset = 1'b1;
        idle(1);
        check_zero("rst_commit");
        reset = 1'b0;
        nb = obs_wr.size();
        nd = n_done;
        idle(30);
        check("rst_commit_no_more_wr", 32'(obs_wr.size()), 32'(nb));
        check("rst_commit_partial", 32'(nb < 8), 32'd1);
        check("rst_commit_no_done", 32'(n_done), 32'(nd));
        check("rst_commit_errcnt", 32'(err_cnt), 32'd0);
        check("rst_commit_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
